// File: rtl/fifo_cmd_reader.sv
// fifo_cmd_reader: drains a show-ahead FIFO into one registered valid/ready stage,
// keeping a minimum idle gap between handshakes. Define FIFO_RD_STATS_EN for pop/stall counters.
module fifo_cmd_reader #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  input  logic             i_flush
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0] o_pop_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  localparam int            GW     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] ONE    = GW'(1);

  if (WIDTH < 1 || CNT_W < 1 || GAP_CYCLES < 0) begin : g_bad_param
    $error("fifo_cmd_reader: WIDTH and CNT_W must be >= 1, GAP_CYCLES >= 0");
  end

  // Bit 0 of the encoding doubles as the registered valid flag
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          hs;
  logic          pop;
  logic          gap_long;

  assign o_valid = state_q[0];
  assign hs      = o_valid & i_ready;

  // Reset gates the pop so the FIFO is never drained while we are held in reset
  assign pop = i_rst_n & ~i_fifo_empty & ~i_flush &
               ((state_q == IDLE) | (hs & (GAP_CYCLES == 0)));
  assign o_fifo_rd_en = pop;

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (i_flush)
      gap_cnt_d = '0;
    else if (hs)
      gap_cnt_d = GAP_LD;
    else if (gap_cnt_q != '0)
      gap_cnt_d = gap_cnt_q - ONE;
  end

  assign gap_long = ({1'b0, gap_cnt_d} > {1'b0, ONE});

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else if (pop) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD:    if (hs) state_d = gap_long ? GAP : IDLE;
        GAP:     if (!gap_long) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      o_data    <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      if (pop)
        o_data <= i_fifo_data;
    end
  end

`ifdef FIFO_RD_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Statistics survive flush; only reset clears them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pop_cnt   <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (pop)
        o_pop_cnt <= sat_inc(o_pop_cnt);
      if (o_valid && !i_ready)
        o_stall_cnt <= sat_inc(o_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Bench for fifo_cmd_reader: two instances (GAP_CYCLES 0 and 2) fed from queue FIFOs,
// checked against a timestamp-based reference model plus a vector table and corner sequences.
module tb_fifo_cmd_reader;
  localparam int W    = 4;
  localparam int NDUT = 2;
  localparam longint NONE = -1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ready;
  logic         flush;
  logic [W-1:0] fdata  [NDUT];
  logic         fempty [NDUT];
  logic         rd_en  [NDUT];
  logic         valid  [NDUT];
  logic [W-1:0] odata  [NDUT];
`ifdef FIFO_RD_STATS_EN
  logic [15:0]  pop_cnt   [NDUT];
  logic [15:0]  stall_cnt [NDUT];
`endif

  always #5 clk = ~clk;

  fifo_cmd_reader #(.WIDTH(W), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_data(fdata[0]), .i_fifo_empty(fempty[0]),
    .o_fifo_rd_en(rd_en[0]), .o_valid(valid[0]), .o_data(odata[0]),
    .i_ready(ready), .i_flush(flush)
`ifdef FIFO_RD_STATS_EN
    , .o_pop_cnt(pop_cnt[0]), .o_stall_cnt(stall_cnt[0])
`endif
  );

  fifo_cmd_reader #(.WIDTH(W), .GAP_CYCLES(2), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_data(fdata[1]), .i_fifo_empty(fempty[1]),
    .o_fifo_rd_en(rd_en[1]), .o_valid(valid[1]), .o_data(odata[1]),
    .i_ready(ready), .i_flush(flush)
`ifdef FIFO_RD_STATS_EN
    , .o_pop_cnt(pop_cnt[1]), .o_stall_cnt(stall_cnt[1])
`endif
  );

  // FIFO contents per instance and the reference model state
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           mvalid  [NDUT];
  logic [W-1:0] mdata   [NDUT];
  longint       last_hs [NDUT];
  bit           epop    [NDUT];
  int           mpops   [NDUT];
  int           mstall  [NDUT];
  longint       cyc;
  int           n_chk;
  int           n_pass;

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [W-1:0] qhead(input int d);
    if (qsize(d) == 0) return '0;
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int d, input logic [W-1:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic qclear();
    q0.delete();
    q1.delete();
  endtask

  task automatic sync_fifo();
    for (int d = 0; d < NDUT; d++) begin
      fempty[d] = (qsize(d) == 0);
      fdata[d]  = qhead(d);
    end
  endtask

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      mvalid[d]  = 1'b0;
      mdata[d]   = '0;
      last_hs[d] = NONE;
      mpops[d]   = 0;
      mstall[d]  = 0;
      epop[d]    = 1'b0;
    end
  endtask

  // Compare all outputs against the model, away from the active edge
  task automatic at_neg();
    bit may_load;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      may_load = !mvalid[d] && ((cyc - last_hs[d]) >= longint'(gap_of(d)));
      epop[d]  = rst_n && (qsize(d) != 0) && !flush &&
                 (may_load || (mvalid[d] && ready && gap_of(d) == 0));
      chk("rd_en", d, 32'(rd_en[d]), 32'(epop[d]));
      chk("valid", d, 32'(valid[d]), 32'(mvalid[d]));
      chk("data",  d, 32'(odata[d]), 32'(mdata[d]));
`ifdef FIFO_RD_STATS_EN
      chk("pop_cnt",   d, 32'(pop_cnt[d]),   32'(mpops[d]));
      chk("stall_cnt", d, 32'(stall_cnt[d]), 32'(mstall[d]));
`endif
    end
  endtask

  // Advance the model across the active edge, then update the FIFO views
  task automatic at_pos();
    bit hs;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      hs = mvalid[d] && ready;
      if (mvalid[d] && !ready) mstall[d]++;
      if (epop[d]) begin
        mdata[d] = qhead(d);
        qpop(d);
        mpops[d]++;
      end
      if (flush) begin
        mvalid[d]  = 1'b0;
        last_hs[d] = NONE;
      end else begin
        if (hs) last_hs[d] = cyc;
        if (epop[d]) mvalid[d] = 1'b1;
        else if (hs) mvalid[d] = 1'b0;
      end
    end
    #1;
    cyc++;
    sync_fifo();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_rd_en", d, 32'(rd_en[d]), 32'd0);
      chk("rst_valid", d, 32'(valid[d]), 32'd0);
      chk("rst_data",  d, 32'(odata[d]), 32'd0);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         ready;
    logic         flush;
    logic         rd0;
    logic         v0;
    logic [W-1:0] d0;
    logic         rd1;
    logic         v1;
    logic [W-1:0] d1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // ready, flush | GAP=0: rd_en, valid, data | GAP=2: rd_en, valid, data
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 4'hA};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 4'hA};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 4'hA};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b1, 4'hB};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'hB};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 4'hB};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b1, 4'hC};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'hC};

    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    rst_n = 1'b0;
    ready = 1'b0;
    flush = 1'b0;
    model_reset();
    qclear();
    sync_fifo();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("init_valid", d, 32'(valid[d]), 32'd0);
      chk("init_data",  d, 32'(odata[d]), 32'd0);
      chk("init_rd_en", d, 32'(rd_en[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Three queued words A,B,C: back-to-back on GAP=0, spaced by 3 on GAP=2
    for (int d = 0; d < NDUT; d++) begin
      qpush(d, 4'hA);
      qpush(d, 4'hB);
      qpush(d, 4'hC);
    end
    sync_fifo();
    for (int i = 0; i < 9; i++) begin
      ready = tbl[i].ready;
      flush = tbl[i].flush;
      at_neg();
      chk("tbl_rd_en", 0, 32'(rd_en[0]), 32'(tbl[i].rd0));
      chk("tbl_valid", 0, 32'(valid[0]), 32'(tbl[i].v0));
      chk("tbl_data",  0, 32'(odata[0]), 32'(tbl[i].d0));
      chk("tbl_rd_en", 1, 32'(rd_en[1]), 32'(tbl[i].rd1));
      chk("tbl_valid", 1, 32'(valid[1]), 32'(tbl[i].v1));
      chk("tbl_data",  1, 32'(odata[1]), 32'(tbl[i].d1));
      at_pos();
    end

    // Stall: word held stable for 5 cycles with no pop, then accepted
    qclear();
    do_reset();
    ready = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      qpush(d, 4'h5);
      qpush(d, 4'h6);
    end
    sync_fifo();
    at_neg();
    at_pos();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      for (int d = 0; d < NDUT; d++) begin
        chk("stall_data",  d, 32'(odata[d]), 32'h5);
        chk("stall_rd_en", d, 32'(rd_en[d]), 32'd0);
      end
      at_pos();
    end
    ready = 1'b1;
    at_neg();
    for (int d = 0; d < NDUT; d++) begin
      chk("stall_accept", d, 32'(valid[d]), 32'd1);
`ifdef FIFO_RD_STATS_EN
      chk("stall_total", d, 32'(stall_cnt[d]), 32'd5);
`endif
    end
    at_pos();
    repeat (4) begin at_neg(); at_pos(); end

    // Empty FIFO: nothing popped; a pushed word pops at once and is valid next cycle
    qclear();
    do_reset();
    ready = 1'b1;
    sync_fifo();
    repeat (3) begin
      at_neg();
      for (int d = 0; d < NDUT; d++) chk("empty_rd_en", d, 32'(rd_en[d]), 32'd0);
      at_pos();
    end
    for (int d = 0; d < NDUT; d++) qpush(d, 4'hD);
    sync_fifo();
    at_neg();
    for (int d = 0; d < NDUT; d++) chk("fill_rd_en", d, 32'(rd_en[d]), 32'd1);
    at_pos();
    at_neg();
    for (int d = 0; d < NDUT; d++) begin
      chk("fill_valid", d, 32'(valid[d]), 32'd1);
      chk("fill_data",  d, 32'(odata[d]), 32'hD);
    end
    at_pos();

    // Flush while holding E with more words queued
    qclear();
    do_reset();
    ready = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      qpush(d, 4'hE);
      qpush(d, 4'h7);
    end
    sync_fifo();
    at_neg(); at_pos();
    at_neg(); at_pos();
    flush = 1'b1;
    at_neg();
    for (int d = 0; d < NDUT; d++) chk("flush_rd_en", d, 32'(rd_en[d]), 32'd0);
    at_pos();
    flush = 1'b0;
    at_neg();
    for (int d = 0; d < NDUT; d++) begin
      chk("flush_valid", d, 32'(valid[d]), 32'd0);
      chk("after_flush_rd_en", d, 32'(rd_en[d]), 32'd1);
    end
    at_pos();
    at_neg();
    for (int d = 0; d < NDUT; d++) chk("after_flush_data", d, 32'(odata[d]), 32'h7);
    at_pos();

    // Reset mid-stream with data pending, then restart from idle
    qclear();
    ready = 1'b1;
    for (int d = 0; d < NDUT; d++) for (int k = 0; k < 4; k++) qpush(d, W'(k + 1));
    sync_fifo();
    repeat (2) begin at_neg(); at_pos(); end
    do_reset();
    at_neg();
    for (int d = 0; d < NDUT; d++) chk("restart_rd_en", d, 32'(rd_en[d]), 32'd1);
    at_pos();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      for (int d = 0; d < NDUT; d++)
        if (qsize(d) < 6 && $urandom_range(0, 2) != 0) qpush(d, W'($urandom));
      sync_fifo();
      if ($urandom_range(0, 199) == 0) do_reset();
      at_neg();
      at_pos();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
